// File: rtl/stack_mem_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port memory between fetch (port 0) and stack (port 1).
// Latency : request seen in IDLE at cycle N, mem_en at N+1, done at N+2 with zero wait states (3-cycle minimum).
// Backpress: holds the captured command on the memory until mem_ready or MAX_WAIT cycles, then reports via done/err.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_req0/i_addr0               fetch request (read-only)         -> o_gnt0/o_done0
//   i_req1/i_addr1/i_we1/i_wdata1 stack request (load/store)      -> o_gnt1/o_done1
//   o_rdata/o_err                read data and timeout flag, qualified by a done pulse
//   o_mem_*/i_mem_rdata/i_mem_ready  memory side
//   o_busy                       arbiter is not idle
module stack_mem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic [ADDR_W-1:0] i_addr0,
    output logic              o_gnt0,
    output logic              o_done0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic              i_we1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt1,
    output logic              o_done1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // Counter value on the last permitted ISSUE cycle.
    localparam logic [7:0] LP_CNT_LAST = 8'(MAX_WAIT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_gnt;
    logic                r_port;
    logic [7:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_any_req;
    logic                w_win_port;
    logic                w_timeout;

    assign w_any_req = i_req0 | i_req1;
    // On a tie the port that did not win last time goes next; otherwise the sole requester wins.
    assign w_win_port = (i_req0 & i_req1) ? ~r_last_gnt : i_req1;
    assign w_timeout  = (r_cnt == LP_CNT_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: if (i_mem_ready || w_timeout) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Command capture, wait counter, read data and error flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_last_gnt <= 1'b1;
            r_port     <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_port  <= w_win_port;
                        r_addr  <= w_win_port ? i_addr1 : i_addr0;
                        // Fetch port is read-only: store fields are forced to zero.
                        r_we    <= w_win_port & i_we1;
                        r_wdata <= w_win_port ? i_wdata1 : '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_cnt + 8'd1;
                    // mem_ready wins over a timeout landing on the same cycle.
                    if (i_mem_ready) begin
                        if (!r_we) r_rdata <= i_mem_rdata;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_last_gnt <= r_port;
                    r_cnt      <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Output logic: all strobes derive from state, so reset clears them immediately.
    always_comb begin
        o_gnt0      = 1'b0;
        o_gnt1      = 1'b0;
        o_done0     = 1'b0;
        o_done1     = 1'b0;
        o_err       = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
        o_rdata     = r_rdata;
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: begin
                o_mem_en = 1'b1;
                o_mem_we = r_we;
                o_gnt0   = ~r_port;
                o_gnt1   = r_port;
            end
            S_RESP: begin
                o_gnt0  = ~r_port;
                o_gnt1  = r_port;
                o_done0 = ~r_port;
                o_done1 = r_port;
                o_err   = r_err;
            end
            default: begin
                o_mem_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Purpose : scoreboard bench for stack_mem_arbiter with a wait-state memory model.
// Latency : checks request-to-done cycle counts and per-access mem_en lengths.
// Backpress: memory model inserts a programmable number of wait states (large = never ready).
module tb_stack_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic [4:0] addr0 = '0;
    logic       gnt0, done0;
    logic       req1 = 1'b0;
    logic [4:0] addr1 = '0;
    logic       we1 = 1'b0;
    logic [7:0] wdata1 = '0;
    logic       gnt1, done1;
    logic [7:0] rdata;
    logic       err;
    logic       mem_en, mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready = 1'b0;
    logic       busy;

    always #5 clk = ~clk;

    stack_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_WAIT(15)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_req0(req0), .i_addr0(addr0), .o_gnt0(gnt0), .o_done0(done0),
        .i_req1(req1), .i_addr1(addr1), .i_we1(we1), .i_wdata1(wdata1),
        .o_gnt1(gnt1), .o_done1(done1),
        .o_rdata(rdata), .o_err(err),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
        .o_busy(busy)
    );

    typedef struct {
        logic       port;
        logic [4:0] addr;
        logic       we;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
        int         en_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Memory model: asserts ready after mem_wait wait states of a continuous mem_en burst.
    int         mem_wait = 0;
    logic [7:0] mem_val  = '0;
    int         mem_cnt  = 0;
    assign mem_rdata = mem_val;

    always @(negedge clk) begin
        if (mem_en) begin
            mem_ready = (mem_cnt == mem_wait);
            mem_cnt++;
        end else begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end
    end

    // Monitor: checks the in-flight access against the head of the scoreboard, pops on done.
    int mon_en = 0;
    always @(negedge clk) begin
        if (busy) chk("gnt_overlap", {31'd0, gnt0 & gnt1}, 32'd0);
        if (sb.size() > 0) begin
            if (mem_en) begin
                mon_en++;
                chk("mem_addr", {27'd0, mem_addr}, {27'd0, sb[0].addr});
                chk("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
                chk("issue_gnt", {30'd0, gnt1, gnt0}, sb[0].port ? 32'd2 : 32'd1);
                if (sb[0].we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, sb[0].wdata});
            end
            if (done0 | done1) begin
                chk("done_port", {31'd0, done1}, {31'd0, sb[0].port});
                chk("done_onehot", {31'd0, done0 & done1}, 32'd0);
                chk("rdata", {24'd0, rdata}, {24'd0, sb[0].rdata});
                chk("err", {31'd0, err}, {31'd0, sb[0].err});
                chk("en_cycles", mon_en, sb[0].en_cycles);
                void'(sb.pop_front());
                mon_en = 0;
            end
        end else if (done0 | done1) begin
            chk("unexpected_done", {30'd0, done1, done0}, 32'd0);
        end
    end

    function automatic void expect_txn(input logic port, input logic [4:0] addr, input logic we,
                                       input logic [7:0] wdata, input logic [7:0] rd,
                                       input logic e, input int en);
        exp_t x;
        x.port = port; x.addr = addr; x.we = we; x.wdata = wdata;
        x.rdata = rd; x.err = e; x.en_cycles = en;
        sb.push_back(x);
    endfunction

    // Single-requester transaction; optional addr1 change mid-ISSUE.
    task automatic txn(input logic port, input logic [4:0] addr, input logic we,
                       input logic [7:0] wdata, input int wt, input logic [7:0] rv,
                       input logic [7:0] exp_rd, input logic exp_err, input int exp_en,
                       input bit poke_addr);
        int cyc;
        bit got;
        expect_txn(port, addr, we, wdata, exp_rd, exp_err, exp_en);
        @(negedge clk);
        mem_wait = wt;
        mem_val  = rv;
        if (port) begin
            req1 = 1'b1; addr1 = addr; we1 = we; wdata1 = wdata;
        end else begin
            req0 = 1'b1; addr0 = addr;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (poke_addr && cyc == 2) addr1 = 5'h09;
            if (done0 | done1) got = 1'b1;
        end
        chk("latency", cyc, exp_en + 1);
        req0 = 1'b0;
        req1 = 1'b0;
        we1  = 1'b0;
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    // Both ports request continuously until n done pulses have been seen.
    task automatic both(input int n, input logic [4:0] a0, input logic [4:0] a1, input logic [7:0] rv);
        int cnt;
        int cyc;
        @(negedge clk);
        mem_wait = 0;
        mem_val  = rv;
        req0 = 1'b1; addr0 = a0;
        req1 = 1'b1; addr1 = a1; we1 = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done0 | done1) cnt++;
        end
        chk("contention_dones", cnt, n);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk("busy_after_both", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2;
        chk("reset_strobes", {24'd0, gnt0, gnt1, done0, done1, busy, mem_en, mem_we, err}, 32'd0);
        chk("reset_rdata", {24'd0, rdata}, 32'd0);
        chk("reset_mem_bus", {19'd0, mem_addr, mem_wdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single fetch, zero wait states.
        txn(1'b0, 5'h03, 1'b0, 8'h00, 0, 8'hA5, 8'hA5, 1'b0, 1, 1'b0);
        // Store with 3 wait states; rdata keeps A5.
        txn(1'b1, 5'h1F, 1'b1, 8'h3C, 3, 8'hEE, 8'hA5, 1'b0, 4, 1'b0);
        // Timeout: never ready -> 15 ISSUE cycles, err, rdata unchanged.
        txn(1'b0, 5'h0A, 1'b0, 8'h00, 1000, 8'h77, 8'hA5, 1'b1, 15, 1'b0);
        // Following access completes normally.
        txn(1'b0, 5'h0B, 1'b0, 8'h00, 1, 8'h5E, 8'h5E, 1'b0, 2, 1'b0);
        // addr1 changes mid-ISSUE; captured 04 must stay on the bus.
        txn(1'b1, 5'h04, 1'b0, 8'h00, 2, 8'hC3, 8'hC3, 1'b0, 3, 1'b1);

        // Contention: last winner was port 1, so order is 0,1,0,1.
        expect_txn(1'b0, 5'h02, 1'b0, 8'h00, 8'h66, 1'b0, 1);
        expect_txn(1'b1, 5'h12, 1'b0, 8'h00, 8'h66, 1'b0, 1);
        expect_txn(1'b0, 5'h02, 1'b0, 8'h00, 8'h66, 1'b0, 1);
        expect_txn(1'b1, 5'h12, 1'b0, 8'h00, 8'h66, 1'b0, 1);
        both(4, 5'h02, 5'h12, 8'h66);

        // Port 0 wins alone so a tie after reset would otherwise go to port 1.
        txn(1'b0, 5'h01, 1'b0, 8'h00, 0, 8'h42, 8'h42, 1'b0, 1, 1'b0);

        // Asynchronous reset during a stalled port 1 access.
        @(negedge clk);
        mem_wait = 1000;
        req1 = 1'b1; addr1 = 5'h08; we1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_active", {29'd0, mem_en, gnt1, busy}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_strobes", {29'd0, mem_en, gnt1, busy}, 32'd0);
        chk("async_reset_rdata", {24'd0, rdata}, 32'd0);
        req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset goes to port 0 first.
        expect_txn(1'b0, 5'h06, 1'b0, 8'h00, 8'h99, 1'b0, 1);
        expect_txn(1'b1, 5'h07, 1'b0, 8'h00, 8'h99, 1'b0, 1);
        both(2, 5'h06, 5'h07, 8'h99);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_mem_arbiter.md
Name: stack_mem_arbiter

Overview:
- Shares the single-port instruction/data memory between two requesters: port 0 is the fetch unit (instruction reads) and port 1 is the stack unit (load/store).
- Arbitrates with round-robin priority and captures the winner's command.
- Drives the memory until it signals ready, or until a wait timeout expires.
- Returns read data plus a one-cycle done pulse to the winner. Sits between the multicycle controller/datapath and the memory model.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 8, memory data width.
- MAX_WAIT, 15, cycles in ISSUE without mem_ready before the access is aborted with err (1..255).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  fetch request; held high until done0.
- addr0  input  ADDR_W  fetch address; read-only port.
- gnt0  output  1  port 0 owns the memory.
- done0  output  1  one-cycle completion pulse, port 0.
- req1  input  1  stack request; held high until done1.
- addr1  input  ADDR_W  stack address.
- we1  input  1  1 = store, 0 = load.
- wdata1  input  DATA_W  store data.
- gnt1  output  1  port 1 owns the memory.
- done1  output  1  one-cycle completion pulse, port 1.
- rdata  output  DATA_W  read data; valid when a done pulse accompanies a read.
- err  output  1  high with done when the access timed out.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- mem_ready  input  1  memory completes the access this cycle.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including rdata and the captured command registers; last_gnt = 1, so port 0 wins the first tie; wait counter = 0. Any in-flight access is abandoned and mem_en drops immediately.
- States:
  - IDLE: arbitrate.
  - ISSUE: drive memory.
  - RESP: report to requester.
- IDLE:
  - No requests: stay in IDLE.
  - One request: that port wins.
  - Both requests: the port != last_gnt wins.
  - On the winning edge, register the winner's addr, we and wdata (port 0 forces we = 0, wdata = 0), set the grant and go to ISSUE.
- ISSUE:
  - mem_en = 1; mem_we/mem_addr/mem_wdata come from the captured registers. The grant is held.
  - Wait counter increments each cycle.
  - mem_ready = 1: if the captured we = 0, latch mem_rdata into rdata; go to RESP, err = 0.
  - Counter reaches MAX_WAIT with mem_ready still 0: go to RESP, err = 1, rdata unchanged.
- RESP:
  - mem_en = 0.
  - done of the granted port = 1 for exactly this cycle, grant still high, err valid.
  - On exit: last_gnt = granted port, grant cleared, counter cleared, go to IDLE.
- Latency: request seen in IDLE at cycle N; mem_en at N+1; done at N+2 with zero wait states. Minimum transaction is 3 cycles.
- Requester rules:
  - Deassert req on the edge at which done is sampled high. A req still high in the following IDLE cycle is a new request.
  - Changes to addr/we/wdata after capture are ignored.
  - A req dropped mid-transaction does not abort it; done still pulses.
- rdata holds its value between reads and is not changed by writes or timeouts.
- gnt0 and gnt1 are never high together; done0 and done1 are never high together.
- mem_ready outside ISSUE is ignored.

Test Plan:
- Reset then a single fetch: req0 = 1, addr0 = 5'h03, memory returns 8'hA5 with mem_ready at the first ISSUE cycle -> mem_en high in cycle 1, done0 and rdata = 8'hA5 in cycle 2, busy low in cycle 3.
- Simultaneous req0 and req1 held continuously for four transactions -> grant order 0,1,0,1; gnt0 and gnt1 never overlap.
- Store: req1 = 1, we1 = 1, addr1 = 5'h1F, wdata1 = 8'h3C, mem_ready after 3 wait cycles -> mem_we = 1, mem_wdata = 8'h3C for 4 cycles; done1 pulses once; rdata keeps its previous value.
- Timeout: mem_ready tied 0, MAX_WAIT = 15 -> mem_en high exactly 15 cycles; done0 and err = 1 together; next access completes with err = 0.
- Command stability: change addr1 from 5'h04 to 5'h09 during ISSUE -> mem_addr stays 5'h04 throughout the access.
- Asynchronous reset mid-ISSUE: rst low between clock edges -> mem_en, gnt1 and busy low immediately; after release, a tie is won by port 0.
